// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module   : data_memory
// Purpose  : Byte-addressable 64-bit data memory for the MEM stage of the
//            RISC-V datapath. Doublewords are stored little-endian in a byte
//            array. Writes commit on the rising clock edge. Reads are fully
//            combinational from mem_read, address and the array contents.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   MEM_BYTES  capacity in bytes (power of two, >= 8)
//   ADDR_W     address port width
//   DATA_W     data width, fixed at 64 (8 byte lanes)
// Ports
//   clk         in   1       system clock, writes commit on rising edge
//   reset       in   1       asynchronous active-high, clears whole array
//   mem_read    in   1       read enable, gates read_data
//   mem_write   in   1       write enable, sampled at rising clk edge
//   address     in   ADDR_W  byte address of the least-significant byte
//   write_data  in   DATA_W  doubleword to store
//   read_data   out  DATA_W  doubleword at address, or zero
// Build option
//   DATAMEM_ALIGN_CHECK_EN  when defined, accesses with address[2:0] != 0
//                           are misaligned: writes are dropped and reads
//                           return zero. When undefined, any in-range
//                           address (aligned or not) is accessed normally.
// ============================================================================
module data_memory #(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data
);

  localparam int c_LANES = 8;
  localparam int c_IDX_W = $clog2(MEM_BYTES);
  // Highest legal start address. The comparison is done on the full address
  // width so upper address bits can never alias into the array.
  localparam logic [ADDR_W-1:0] c_LAST_START = ADDR_W'(MEM_BYTES - c_LANES);

  // Byte storage and its next-state image.
  logic [7:0] mem_q [MEM_BYTES];
  logic [7:0] mem_d [MEM_BYTES];

  logic              w_in_range;
  logic              w_align_ok;
  logic              w_access_ok;
  logic              w_wr_ok;
  logic [c_IDX_W-1:0] w_base;
  logic [DATA_W-1:0] w_rd_lanes;

  assign w_in_range = (address <= c_LAST_START);

`ifdef DATAMEM_ALIGN_CHECK_EN
  assign w_align_ok = (address[2:0] == 3'b000);
`else
  assign w_align_ok = 1'b1;
`endif

  assign w_access_ok = w_in_range & w_align_ok;
  assign w_wr_ok     = mem_write & w_access_ok;

  // Once the access is known to be in range, the low index bits alone select
  // the start byte, and base+7 cannot run past the end of the array.
  assign w_base = address[c_IDX_W-1:0];

  // --------------------------------------------------------------------------
  // Next-state of the array: hold everything, then overlay the 8 addressed
  // bytes on a legal write. Lane k of write_data goes to byte base+k.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < MEM_BYTES; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (w_wr_ok) begin
      for (int k = 0; k < c_LANES; k++) begin
        mem_d[w_base + c_IDX_W'(k)] = write_data[8*k +: 8];
      end
    end
  end

  // Asynchronous reset has priority, so a write edge while reset is high is
  // discarded and the array stays cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read path: gather bytes base..base+7 into lanes 0..7 (little-endian).
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < c_LANES; k++) begin : g_rd_lane
    assign w_rd_lanes[8*k +: 8] = mem_q[w_base + c_IDX_W'(k)];
  end

  // Reset is included so the output drops the instant reset asserts, even
  // before the cleared array is visible through the lane mux.
  assign read_data = (mem_read && w_access_ok && !reset) ? w_rd_lanes
                                                         : {DATA_W{1'b0}};

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory
// Purpose  : Self-checking bench for data_memory. A table of directed
//            vectors ({write, read, address, data, expected read_data}) is
//            applied one per clock cycle, followed by hand-written sequences
//            for asynchronous reset behaviour.
// Revision : 1.0  initial release
// ============================================================================
module tb_data_memory;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] address;
  logic [63:0] write_data;
  logic [63:0] read_data;

  int errors;
  int checks;

  data_memory #(
    .MEM_BYTES(256),
    .ADDR_W   (64),
    .DATA_W   (64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic        re;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp;   // read_data expected before the write edge
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string n, input logic we, input logic re,
                              input logic [63:0] a, input logic [63:0] d,
                              input logic [63:0] e);
    vec_t v;
    v.name = n; v.we = we; v.re = re; v.addr = a; v.wdata = d; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic check(input string n, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: read_data=%h expected=%h", n, got, exp);
    end
  endtask

  // Drive one access for a full cycle: inputs change at negedge, the
  // combinational output is sampled 1 ns later, the write lands on posedge.
  task automatic apply(input string n, input logic we, input logic re,
                       input logic [63:0] a, input logic [63:0] d,
                       input logic [63:0] e);
    @(negedge clk);
    mem_write  = we;
    mem_read   = re;
    address    = a;
    write_data = d;
    #1;
    check(n, read_data, e);
  endtask

  localparam logic [63:0] c_DEAD = 64'hDEADBEEFCAFEBABE;
  localparam logic [63:0] c_1234 = 64'h123456789ABCDEF0;

`ifdef DATAMEM_ALIGN_CHECK_EN
  localparam logic [63:0] c_RD_11   = 64'h0;
  localparam logic [63:0] c_RD_30   = 64'h1111111111111111;
  localparam logic [63:0] c_RD_38   = 64'h0;
`else
  localparam logic [63:0] c_RD_11   = 64'hF0DEADBEEFCAFEBA;
  localparam logic [63:0] c_RD_30   = 64'h2222222211111111;
  localparam logic [63:0] c_RD_38   = 64'h0000000022222222;
`endif

  initial begin
    errors     = 0;
    checks     = 0;
    reset      = 1'b1;
    mem_read   = 1'b1;
    mem_write  = 1'b0;
    address    = 64'h10;
    write_data = '0;

    // Vector table
    add("rst_rd_10",      0, 1, 64'h10,  0, 64'h0);
    add("rst_rd_f8",      0, 1, 64'hF8,  0, 64'h0);
    add("wr_18",          1, 0, 64'h18,  c_1234, 64'h0);
    add("wr_10_pre",      1, 1, 64'h10,  c_DEAD, 64'h0);
    add("rd_10_post",     0, 1, 64'h10,  0, c_DEAD);
    add("rd_10_disabled", 0, 0, 64'h10,  0, 64'h0);
    add("rd_11_unaligned",0, 1, 64'h11,  0, c_RD_11);
    add("wr_20",          1, 0, 64'h20,  c_1234, 64'h0);
    add("rd_20",          0, 1, 64'h20,  0, c_1234);
    add("rd_10_kept",     0, 1, 64'h10,  0, c_DEAD);
    add("wr_f9_oob",      1, 1, 64'hF9,  64'hAAAAAAAAAAAAAAAA, 64'h0);
    add("rd_f9_oob",      0, 1, 64'hF9,  0, 64'h0);
    add("rd_f8_untouched",0, 1, 64'hF8,  0, 64'h0);
    add("wr_f8",          1, 0, 64'hF8,  64'h0102030405060708, 64'h0);
    add("rd_f8",          0, 1, 64'hF8,  0, 64'h0102030405060708);
    add("wr_alias",       1, 1, 64'h1_0000_0010, 64'h5555555555555555, 64'h0);
    add("rd_alias",       0, 1, 64'h1_0000_0010, 0, 64'h0);
    add("rd_10_no_alias", 0, 1, 64'h10,  0, c_DEAD);
    add("rd_top_oob",     0, 1, 64'hFFFFFFFFFFFFFFF8, 0, 64'h0);
    add("wr_30",          1, 0, 64'h30,  64'h1111111111111111, 64'h0);
    add("wr_34_overlap",  1, 0, 64'h34,  64'h2222222222222222, 64'h0);
    add("rd_30_overlap",  0, 1, 64'h30,  0, c_RD_30);
    add("rd_38_overlap",  0, 1, 64'h38,  0, c_RD_38);
    add("rd_f0",          0, 1, 64'hF0,  0, 64'h0);

    // Reset held: output is zero even with mem_read set
    repeat (2) @(posedge clk);
    #1;
    check("rd_during_reset", read_data, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i].name, vecs[i].we, vecs[i].re, vecs[i].addr,
            vecs[i].wdata, vecs[i].exp);
    end

    // Asynchronous reset pulse between edges
    apply("pre_async_rd_10", 0, 1, 64'h10, 0, c_DEAD);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_drop", read_data, 64'h0);

    // Write attempt across an edge while reset is held must be blocked
    mem_write  = 1'b1;
    write_data = 64'h7777777777777777;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset     = 1'b0;
    mem_write = 1'b0;
    #1;
    check("blocked_wr_10", read_data, 64'h0);

    apply("post_rst_rd_20", 0, 1, 64'h20, 0, 64'h0);
    apply("post_rst_rd_18", 0, 1, 64'h18, 0, 64'h0);
    apply("post_rst_rd_f8", 0, 1, 64'hF8, 0, 64'h0);
    apply("post_rst_rd_30", 0, 1, 64'h30, 0, 64'h0);

    // First edge after deassertion takes the write
    apply("first_wr_50", 1, 1, 64'h50, 64'h0A0B0C0D0E0F1011, 64'h0);
    apply("first_rd_50", 0, 1, 64'h50, 0, 64'h0A0B0C0D0E0F1011);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected bench completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
